// File: rtl/moa_pkg.sv
// Shared types and constant helpers for the multi-operand accumulator.
package moa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } moa_state_e;

    // Ceiling log2; used for count, index and sum widths at elaboration time.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/moa_operand_buf.sv
// N x W operand register file: one write port, one asynchronous read port, storage not reset.
module moa_operand_buf
    import moa_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned N = 5,
    localparam int unsigned AW = clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata_c
);

    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/multi_operand_accumulator.sv
// Collects up to N operands and sums them one per cycle.
// Define MOA_SIGNED_EN for two's-complement operands and a signed result.
module multi_operand_accumulator
    import moa_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned N = 5,
    localparam int unsigned CW = clog2(N + 1),
    localparam int unsigned SW = W + clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  din,
    input  logic          go,
    input  logic          clear,
    output logic [SW-1:0] sum,
    output logic          sum_valid,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovf_err
);

    localparam int unsigned AW = clog2(N);

    moa_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;

    logic          we_c;
    logic [AW-1:0] waddr_c;
    logic [W-1:0]  rd_data_c;
    logic [SW-1:0] ext_c;
    logic          start_c;

    moa_operand_buf #(
        .W (W),
        .N (N)
    ) u_buf (
        .clk     (clk),
        .we      (we_c),
        .waddr   (waddr_c),
        .wdata   (din),
        .raddr   (idx_q),
        .rdata_c (rd_data_c)
    );

`ifdef MOA_SIGNED_EN
    assign ext_c = SW'($signed(rd_data_c));
`else
    assign ext_c = SW'(rd_data_c);
`endif

    // Next-state, datapath and write-port control; clear outranks go, go outranks load.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        we_c    = 1'b0;
        waddr_c = AW'(count_q);
        start_c = 1'b0;

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        start_c = 1'b1;
                    end else if (load) begin
                        if (count_q < CW'(N)) begin
                            we_c    = 1'b1;
                            count_d = count_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                SUM: begin
                    acc_d = acc_q + ext_c;
                    idx_d = idx_q + AW'(1);
                    if (CW'(idx_q) == count_q - CW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (go) begin
                        start_c = 1'b1;
                    end else if (load) begin
                        we_c    = 1'b1;
                        waddr_c = '0;
                        count_d = CW'(1);
                        acc_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // An empty set completes immediately with a zero total.
            if (start_c) begin
                acc_d   = '0;
                idx_d   = '0;
                state_d = (count_q == '0) ? DONE : SUM;
            end
        end

        busy_d  = (state_d == SUM);
        valid_d = (state_d == DONE);
        full_d  = (count_d == CW'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            full_q  <= full_d;
        end
    end

    assign sum       = acc_q;
    assign sum_valid = valid_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign full      = full_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed bench for multi_operand_accumulator: operand-queue model plus literal checks.
module tb_multi_operand_accumulator;

    localparam int unsigned W  = 4;
    localparam int unsigned N  = 5;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = 7;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [W-1:0]  din;
    logic          go;
    logic          clear;
    logic [SW-1:0] sum;
    logic          sum_valid;
    logic          busy;
    logic [CW-1:0] count;
    logic          full;
    logic          ovf_err;

    multi_operand_accumulator #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       (din),
        .go        (go),
        .clear     (clear),
        .sum       (sum),
        .sum_valid (sum_valid),
        .busy      (busy),
        .count     (count),
        .full      (full),
        .ovf_err   (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Model: the stored set as a list of values, plus a phase and a countdown.
    localparam int M_IDLE = 0;
    localparam int M_SUM  = 1;
    localparam int M_DONE = 2;
    int            ops[$];
    int            m_mode   = M_IDLE;
    int            m_rem    = 0;
    bit            m_ovf    = 1'b0;
    logic [SW-1:0] m_sum    = '0;
    logic [SW-1:0] m_target = '0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int opval(input logic [W-1:0] v);
`ifdef MOA_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    task automatic model_start();
        int t;
        t = 0;
        foreach (ops[i]) t += ops[i];
        m_target = SW'(t);
        if (ops.size() == 0) begin
            m_mode = M_DONE;
            m_sum  = '0;
        end else begin
            m_mode = M_SUM;
            m_rem  = ops.size();
        end
    endtask

    task automatic model_step();
        if (!rst_n || clear) begin
            ops.delete();
            m_ovf  = 1'b0;
            m_mode = M_IDLE;
            m_rem  = 0;
            m_sum  = '0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (go) model_start();
                    else if (load) begin
                        if (ops.size() < N) ops.push_back(opval(din));
                        else m_ovf = 1'b1;
                    end
                end
                M_SUM: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode = M_DONE;
                        m_sum  = m_target;
                    end
                end
                default: begin
                    if (go) model_start();
                    else if (load) begin
                        ops.delete();
                        ops.push_back(opval(din));
                        m_mode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), (m_mode == M_SUM) ? 1 : 0);
            chk("sum_valid", int'(sum_valid), (m_mode == M_DONE) ? 1 : 0);
            chk("count", int'(count), ops.size());
            chk("full", int'(full), (ops.size() == N) ? 1 : 0);
            chk("ovf_err", int'(ovf_err), int'(m_ovf));
            if (m_mode == M_DONE) chk("sum", int'(sum), int'(m_sum));
        end
    end

    task automatic step(input logic l, input logic [W-1:0] d, input logic g, input logic c);
        load  = l;
        din   = d;
        go    = g;
        clear = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        load  = 1'b0;
        go    = 1'b0;
        clear = 1'b0;
    endtask

    task automatic load_op(input logic [W-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    // Issues go (optionally with load) and measures cycles until sum_valid.
    task automatic go_timed(input string nm, input logic l, input logic [W-1:0] d,
                            input int exp_lat, input int exp_busy);
        int lat;
        int bz;
        step(l, d, 1'b1, 1'b0);
        lat = 1;
        bz  = int'(busy);
        while (!sum_valid && lat < 40) begin
            step(1'b0, '0, 1'b0, 1'b0);
            lat++;
            bz += int'(busy);
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_cycles"}, bz, exp_busy);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        din   = '0;
        go    = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_count", int'(count), 0);
        chk("reset_sum", int'(sum), 0);
        chk("reset_flags", int'({busy, sum_valid, full, ovf_err}), 0);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Five operands, full set
        for (int i = 11; i <= 15; i++) load_op(W'(i));
        go_timed("five_ops", 1'b0, '0, 6, 5);
`ifdef MOA_SIGNED_EN
        chk("five_ops_sum", int'(sum), 113);
`else
        chk("five_ops_sum", int'(sum), 65);
`endif
        chk("five_ops_count", int'(count), 5);
        chk("five_ops_full", int'(full), 1);

        // Overflowing load is dropped
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) load_op(4'd15);
        load_op(4'd3);
        chk("ovf_flag", int'(ovf_err), 1);
        chk("ovf_count", int'(count), 5);
        go_timed("ovf_set", 1'b0, '0, 6, 5);
`ifdef MOA_SIGNED_EN
        chk("ovf_sum", int'(sum), 123);
`else
        chk("ovf_sum", int'(sum), 75);
`endif

        // Empty set
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clear_ovf", int'(ovf_err), 0);
        go_timed("empty", 1'b0, '0, 1, 0);
        chk("empty_sum", int'(sum), 0);

        // Clear aborts on the second SUM cycle
        step(1'b0, '0, 1'b0, 1'b1);
        load_op(4'd1); load_op(4'd2); load_op(4'd3);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("abort_count", int'(count), 0);
        chk("abort_sum", int'(sum), 0);
        chk("abort_state", int'({busy, sum_valid}), 0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        // go beats load in DONE
        load_op(4'd1); load_op(4'd2); load_op(4'd3);
        go_timed("sum6", 1'b0, '0, 4, 3);
        chk("sum6_sum", int'(sum), 6);
        go_timed("resum", 1'b1, 4'd7, 4, 3);
        chk("resum_sum", int'(sum), 6);
        chk("resum_count", int'(count), 3);

        // load in DONE starts a new set
        load_op(4'd5);
        chk("newset_count", int'(count), 1);
        chk("newset_valid", int'(sum_valid), 0);
        go_timed("newset", 1'b0, '0, 2, 1);
        chk("newset_sum", int'(sum), 5);

        // load and go ignored during SUM
        step(1'b0, '0, 1'b0, 1'b1);
        load_op(4'd4); load_op(4'd5);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 4'd1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("ign_valid", int'(sum_valid), 1);
        chk("ign_sum", int'(sum), 9);
        chk("ign_count", int'(count), 2);

        // Reset mid-summation
        step(1'b0, '0, 1'b0, 1'b1);
        load_op(4'd6); load_op(4'd6); load_op(4'd6);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_sum", int'(sum), 0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        chk("post_rst_sum", int'(sum), 0);
        chk("post_rst_valid", int'(sum_valid), 0);
        load_op(4'd2);
        go_timed("post_rst", 1'b0, '0, 2, 1);
        chk("post_rst_total", int'(sum), 2);

        // Mixed-sign operands
        step(1'b0, '0, 1'b0, 1'b1);
        load_op(4'd8); load_op(4'd7); load_op(4'd15);
        go_timed("mixed", 1'b0, '0, 4, 3);
`ifdef MOA_SIGNED_EN
        chk("mixed_sum", int'(sum), 126);
`else
        chk("mixed_sum", int'(sum), 30);
`endif
        step(1'b0, '0, 1'b0, 1'b1);
        chk("done_clear_sum", int'(sum), 0);
        step(1'b0, '0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
